// File: rtl/keypad_encoder.sv
// keypad_encoder: plays 3-bit key codes as 7-bit keypad line patterns.
// Each key is held for HOLD_CYCLES cycles (PRESS) and then released
// (all-zero) for GAP_CYCLES cycles (GAP). done pulses on the final GAP cycle.
// Optional feature: define KEYPAD_ENCODER_FIFO_EN to add a 4-entry key FIFO
// in front of the FSM. Without it, only one key is accepted at a time, and
// only while idle.
module keypad_encoder #(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned GAP_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  output logic [6:0] keypad,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Counter reload values: the counter holds "cycles remaining after this one".
  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] GAP_LOAD  = 16'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  code_q, code_d;
  logic [6:0]  keypad_q, keypad_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Key source seen by the FSM: a pending key and its code, and whether
  // the FSM starts playing that key this cycle.
  logic        avail;
  logic [2:0]  avail_code;
  logic        take;

  // Fixed code-to-pattern map (MSB is keypad[6]).
  function automatic logic [6:0] key_pattern(input logic [2:0] c);
    logic [6:0] p;
    case (c)
      3'd0:    p = 7'b0001001;
      3'd1:    p = 7'b0010010;
      3'd2:    p = 7'b0100010;
      3'd3:    p = 7'b0010100;
      3'd4:    p = 7'b0001100;
      3'd5:    p = 7'b0101000;
      3'd6:    p = 7'b1001000;
      default: p = 7'b0101100;
    endcase
    return p;
  endfunction

`ifdef KEYPAD_ENCODER_FIFO_EN
  logic [2:0] fifo_mem [4];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;

  assign fifo_full  = (count_q == 3'd4);
  assign fifo_empty = (count_q == '0);
  assign key_ready  = !rst && !fifo_full;
  assign push       = key_valid && key_ready;
  assign avail      = !fifo_empty;
  assign avail_code = fifo_mem[rd_ptr_q];

  // FIFO pointer and occupancy next-state; the FSM's take is the pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 2'd1;
    if (take) rd_ptr_d = rd_ptr_q + 2'd1;
    case ({push, take})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointer and occupancy registers; reset empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents are irrelevant while count_q is zero.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= key_code;
  end
`else
  // Without a queue, a key can only be taken while idle.
  assign key_ready  = !rst && (state_q == IDLE);
  assign avail      = key_valid && key_ready;
  assign avail_code = key_code;
`endif

  // State, counter, captured code and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      code_q   <= '0;
      keypad_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      keypad_q <= keypad_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next state: counter reloads on phase entry and only decrements from non-zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (avail) begin
          take    = 1'b1;
          state_d = PRESS;
          cnt_d   = HOLD_LOAD;
        end
      end
      PRESS: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          if (avail) begin
            take    = 1'b1;
            state_d = PRESS;
            cnt_d   = HOLD_LOAD;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    code_d = take ? avail_code : code_q;
  end

  // Outputs are derived from the next state so that the registered
  // outputs line up with the state register in the same cycle.
  always_comb begin
    keypad_d = '0;
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == GAP) && (cnt_d == '0);
    if (state_d == PRESS) keypad_d = key_pattern(code_d);
  end

  assign keypad = keypad_q;
  assign busy   = busy_q;
  assign done   = done_q;

  // A pattern is only ever driven while pressing.
  a_pattern_only_in_press : assert property (@(posedge clk)
    (keypad_q != '0) |-> (state_q == PRESS));

  // done marks only the final cycle of a GAP.
  a_done_last_gap : assert property (@(posedge clk)
    done_q |-> ((state_q == GAP) && (cnt_q == '0)));

endmodule

// File: tb/tb_keypad_encoder.sv
// Testbench for keypad_encoder. The reference model keeps a queue of
// accepted keys, each with its start cycle. Expected outputs come from
// that timeline: pattern for HOLD cycles, then zero for GAP cycles, with
// done on the last GAP cycle. A second instance with 1/1 phases covers
// the minimum-length case.
module tb_keypad_encoder;

  localparam int H = 16;
  localparam int G = 4;

`ifdef KEYPAD_ENCODER_FIFO_EN
  localparam bit FIFO = 1'b1;
`else
  localparam bit FIFO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic [6:0] keypad;
  logic       busy;
  logic       done;

  logic [2:0] m_code;
  logic       m_valid;
  logic       m_ready;
  logic [6:0] m_keypad;
  logic       m_busy;
  logic       m_done;

  always #5 clk = ~clk;

  keypad_encoder #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid),
    .key_ready(key_ready), .keypad(keypad), .busy(busy), .done(done)
  );

  keypad_encoder #(.HOLD_CYCLES(1), .GAP_CYCLES(1)) dut_min (
    .clk(clk), .rst(rst), .key_code(m_code), .key_valid(m_valid),
    .key_ready(m_ready), .keypad(m_keypad), .busy(m_busy), .done(m_done)
  );

  typedef struct {
    logic [2:0] code;
    int         start;
  } key_t;

  key_t       mq[$];
  int         e = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  logic       exp_rdy;
  logic       acc;
  logic [6:0] exp_kp;
  logic       exp_busy;
  logic       exp_done;

  function automatic logic [6:0] spec_pattern(input logic [2:0] c);
    case (c)
      3'd0: return 7'b0001001;
      3'd1: return 7'b0010010;
      3'd2: return 7'b0100010;
      3'd3: return 7'b0010100;
      3'd4: return 7'b0001100;
      3'd5: return 7'b0101000;
      3'd6: return 7'b1001000;
      default: return 7'b0101100;
    endcase
  endfunction

  function automatic logic model_ready(input logic r);
    int pend;
    if (r) return 1'b0;
    if (FIFO) begin
      pend = 0;
      foreach (mq[i]) if (mq[i].start > e) pend++;
      return pend < 4;
    end
    return mq.size() == 0;
  endfunction

  // Apply inputs for the next edge and predict key_ready.
  task automatic drive(input logic r, input logic v, input logic [2:0] c);
    rst = r;
    key_valid = v;
    key_code = c;
    #1;
    exp_rdy = model_ready(r);
  endtask

  // Take one clock edge, update the model, and predict the outputs.
  task automatic advance();
    int st;
    @(posedge clk);
    e++;
    acc = 1'b0;
    if (rst) begin
      mq.delete();
    end else if (key_valid && exp_rdy) begin
      acc = 1'b1;
      if (FIFO) begin
        st = e + 1;
        if (mq.size() > 0 && mq[mq.size()-1].start + H + G > st)
          st = mq[mq.size()-1].start + H + G;
      end else begin
        st = e;
      end
      mq.push_back('{code: key_code, start: st});
    end
    while (mq.size() > 0 && mq[0].start + H + G <= e) void'(mq.pop_front());
    #1;
    exp_kp = '0;
    exp_busy = 1'b0;
    exp_done = 1'b0;
    if (mq.size() > 0 && mq[0].start <= e) begin
      exp_busy = 1'b1;
      if (e < mq[0].start + H) exp_kp = spec_pattern(mq[0].code);
      exp_done = (e == mq[0].start + H + G - 1);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      drive(i < 3, 1'b0, 3'd0);
      n_chk++;
      if (key_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL reset_ready cyc=%0d got=%b exp=%b", e, key_ready, exp_rdy);
      end
      advance();
      n_chk++;
      if ({keypad, busy, done} !== {exp_kp, exp_busy, exp_done}) begin
        n_fail++;
        $display("FAIL reset_out cyc=%0d got=%b/%b/%b exp=%b/%b/%b",
                 e, keypad, busy, done, exp_kp, exp_busy, exp_done);
      end
    end
  endtask

  task automatic test_single();
    int pat_cycles = 0;
    for (int i = 0; i < 26; i++) begin
      drive(1'b0, i == 0, 3'd0);
      n_chk++;
      if (key_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL single_ready cyc=%0d got=%b exp=%b", e, key_ready, exp_rdy);
      end
      advance();
      if (keypad == 7'b0001001) pat_cycles++;
      n_chk++;
      if ({keypad, busy, done} !== {exp_kp, exp_busy, exp_done}) begin
        n_fail++;
        $display("FAIL single_out cyc=%0d got=%b/%b/%b exp=%b/%b/%b",
                 e, keypad, busy, done, exp_kp, exp_busy, exp_done);
      end
    end
    n_chk++;
    if (pat_cycles !== H) begin
      n_fail++;
      $display("FAIL single_hold_len got=%0d exp=%0d", pat_cycles, H);
    end
  endtask

  task automatic test_all_codes();
    int idx = 0;
    logic legal;
    for (int i = 0; i < 8 * (H + G + 2) + 30; i++) begin
      drive(1'b0, idx < 8, 3'(idx));
      n_chk++;
      if (key_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL codes_ready cyc=%0d got=%b exp=%b", e, key_ready, exp_rdy);
      end
      advance();
      if (acc) idx++;
      n_chk++;
      if ({keypad, busy, done} !== {exp_kp, exp_busy, exp_done}) begin
        n_fail++;
        $display("FAIL codes_out cyc=%0d got=%b/%b/%b exp=%b/%b/%b",
                 e, keypad, busy, done, exp_kp, exp_busy, exp_done);
      end
      legal = (keypad == 7'b0);
      for (int k = 0; k < 8; k++) if (keypad == spec_pattern(3'(k))) legal = 1'b1;
      n_chk++;
      if (!legal) begin
        n_fail++;
        $display("FAIL codes_legal cyc=%0d got=%b exp=zero-or-mapped", e, keypad);
      end
    end
    n_chk++;
    if (idx !== 8) begin
      n_fail++;
      $display("FAIL codes_accepted got=%0d exp=8", idx);
    end
  endtask

  task automatic test_reset_mid();
    int t_acc = -1;
    int dones = 0;
    for (int i = 0; i < 40; i++) begin
      drive(t_acc >= 0 && e == t_acc + 4 + int'(FIFO), t_acc < 0, 3'd3);
      n_chk++;
      if (key_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL rstmid_ready cyc=%0d got=%b exp=%b", e, key_ready, exp_rdy);
      end
      advance();
      if (acc) t_acc = e;
      if (done) dones++;
      n_chk++;
      if ({keypad, busy, done} !== {exp_kp, exp_busy, exp_done}) begin
        n_fail++;
        $display("FAIL rstmid_out cyc=%0d got=%b/%b/%b exp=%b/%b/%b",
                 e, keypad, busy, done, exp_kp, exp_busy, exp_done);
      end
    end
    n_chk++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL rstmid_no_done got=%0d exp=0", dones);
    end
  endtask

  task automatic test_held();
    logic [2:0] seq[$];
    int idx = 0;
    if (FIFO) seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    else seq = '{3'd2, 3'd6};
    for (int i = 0; i < 6 * (H + G) + 20; i++) begin
      drive(1'b0, idx < seq.size(), idx < seq.size() ? seq[idx] : 3'd0);
      n_chk++;
      if (key_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL held_ready cyc=%0d got=%b exp=%b", e, key_ready, exp_rdy);
      end
      advance();
      if (acc) idx++;
      n_chk++;
      if ({keypad, busy, done} !== {exp_kp, exp_busy, exp_done}) begin
        n_fail++;
        $display("FAIL held_out cyc=%0d got=%b/%b/%b exp=%b/%b/%b",
                 e, keypad, busy, done, exp_kp, exp_busy, exp_done);
      end
    end
    n_chk++;
    if (idx !== seq.size()) begin
      n_fail++;
      $display("FAIL held_accepted got=%0d exp=%0d", idx, seq.size());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)));
      n_chk++;
      if (key_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL rand_ready cyc=%0d got=%b exp=%b", e, key_ready, exp_rdy);
      end
      advance();
      n_chk++;
      if ({keypad, busy, done} !== {exp_kp, exp_busy, exp_done}) begin
        n_fail++;
        $display("FAIL rand_out cyc=%0d got=%b/%b/%b exp=%b/%b/%b",
                 e, keypad, busy, done, exp_kp, exp_busy, exp_done);
      end
    end
    for (int i = 0; i < 4 * (H + G) + 10; i++) begin
      drive(1'b0, 1'b0, 3'd0);
      advance();
    end
  endtask

  task automatic test_min_cycles();
    logic [2:0] c;
    for (int k = 0; k < 8; k++) begin
      c = 3'($urandom_range(0, 7));
      if (k == 0) c = 3'd7;
      drive(1'b0, 1'b0, 3'd0);
      m_valid = 1'b1;
      m_code = c;
      #1;
      n_chk++;
      if (m_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL min_ready_idle code=%0d got=%b exp=1", c, m_ready);
      end
      advance();
      m_valid = 1'b0;
      m_code = 3'($urandom_range(0, 7));
      for (int j = 0; j < int'(FIFO); j++) begin
        n_chk++;
        if ({m_keypad, m_busy, m_done} !== 9'b0) begin
          n_fail++;
          $display("FAIL min_queued got=%b/%b/%b exp=0/0/0", m_keypad, m_busy, m_done);
        end
        drive(1'b0, 1'b0, 3'd0);
        advance();
      end
      n_chk++;
      if ({m_keypad, m_busy, m_done, m_ready} !== {spec_pattern(c), 1'b1, 1'b0, FIFO}) begin
        n_fail++;
        $display("FAIL min_press code=%0d got=%b/%b/%b/%b exp=%b/1/0/%b",
                 c, m_keypad, m_busy, m_done, m_ready, spec_pattern(c), FIFO);
      end
      drive(1'b0, 1'b0, 3'd0);
      advance();
      n_chk++;
      if ({m_keypad, m_busy, m_done} !== {7'b0, 1'b1, 1'b1}) begin
        n_fail++;
        $display("FAIL min_gap code=%0d got=%b/%b/%b exp=0000000/1/1",
                 c, m_keypad, m_busy, m_done);
      end
      drive(1'b0, 1'b0, 3'd0);
      advance();
      n_chk++;
      if ({m_keypad, m_busy, m_done, m_ready} !== {7'b0, 1'b0, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL min_idle code=%0d got=%b/%b/%b/%b exp=0000000/0/0/1",
                 c, m_keypad, m_busy, m_done, m_ready);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    key_valid = 1'b0;
    key_code = 3'd0;
    m_valid = 1'b0;
    m_code = 3'd0;
    test_reset();
    test_single();
    test_all_codes();
    test_reset_mid();
    test_held();
    test_random();
    test_min_cycles();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
